// File: rtl/arrow_track_if.sv
// Handshake bundle for arrow_track: player/game inputs and track/score outputs.
interface arrow_track_if #(
  parameter int DEPTH   = 8,
  parameter int CODE_W  = 4,
  parameter int SCORE_W = 10
);
  logic                      play;
  logic                      beat;
  logic [CODE_W-1:0]         arrow_in;
  logic [3:0]                btn;
  logic [DEPTH*CODE_W-1:0]   track;
  logic                      hit;
  logic                      miss;
  logic [SCORE_W-1:0]        score;
  logic [6:0]                combo;

  modport master (output play, beat, arrow_in, btn,
                  input  track, hit, miss, score, combo);
  modport slave  (input  play, beat, arrow_in, btn,
                  output track, hit, miss, score, combo);
endinterface

// File: rtl/arrow_track.sv
// Rhythm-game arrow track: arrows shift toward slot 0 on each beat and are judged there.
// Optional macro ARROW_TRACK_REST_EN: every second accepted beat inserts a rest. DEPTH >= 2.
module arrow_track #(
  parameter int DEPTH   = 8,
  parameter int CODE_W  = 4,
  parameter int SCORE_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  arrow_track_if.slave  bus
);
  localparam int TW = DEPTH*CODE_W;

  logic [TW-1:0]      track_q, track_d;
  logic [3:0]         btn_prev_q, btn_prev_d;
  logic               judged_q, judged_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [6:0]         combo_q, combo_d;

  logic [CODE_W-1:0]  slot0, ins;
  logic [3:0]         press, want;
  logic               live, shift, j_hit, j_miss, dep_miss, rest;
`ifdef ARROW_TRACK_REST_EN
  logic               parity_q, parity_d;
`endif

  always_comb begin
    slot0 = track_q[CODE_W-1:0];
    press = bus.btn & ~btn_prev_q;
    // codes 10..13 have low bits 10,11,00,01; subtracting 2 maps them to arrows 0..3
    want  = 4'b0001 << (slot0[1:0] - 2'd2);
    live  = bus.play && (slot0 != '0) && !judged_q;
    j_hit  = live && (press == want);
    j_miss = live && (press != 4'b0000) && (press != want);
    shift  = bus.play && bus.beat;
    dep_miss = shift && (slot0 != '0) && !judged_q && !j_hit && !j_miss;

`ifdef ARROW_TRACK_REST_EN
    rest     = parity_q;
    parity_d = shift ? ~parity_q : parity_q;
`else
    rest     = 1'b0;
`endif
    ins = '0;
    if (!rest && bus.arrow_in >= CODE_W'(10) && bus.arrow_in <= CODE_W'(13))
      ins = bus.arrow_in;

    track_d    = shift ? {ins, track_q[TW-1:CODE_W]} : track_q;
    btn_prev_d = bus.btn;
    judged_d   = judged_q;
    if (shift)               judged_d = 1'b0;
    else if (j_hit || j_miss) judged_d = 1'b1;

    hit_d  = j_hit;
    miss_d = j_miss || dep_miss;

    score_d = score_q;
    if (j_hit && score_q != '1) score_d = score_q + 1'b1;
    combo_d = combo_q;
    if (miss_d)                         combo_d = '0;
    else if (j_hit && combo_q != 7'd127) combo_d = combo_q + 7'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      track_q    <= '0;
      btn_prev_q <= '0;
      judged_q   <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      combo_q    <= '0;
`ifdef ARROW_TRACK_REST_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      track_q    <= track_d;
      btn_prev_q <= btn_prev_d;
      judged_q   <= judged_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
`ifdef ARROW_TRACK_REST_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign bus.track = track_q;
  assign bus.hit   = hit_q;
  assign bus.miss  = miss_q;
  assign bus.score = score_q;
  assign bus.combo = combo_q;
endmodule

// File: tb/tb_arrow_track.sv
// Bench for arrow_track: directed vector table, hand sequences and a random run vs. a slot-array model.
module tb_arrow_track;
  localparam int DEPTH = 8, CODE_W = 4, SCORE_W = 10;
  localparam int SMAX  = (1 << SCORE_W) - 1;
`ifdef ARROW_TRACK_REST_EN
  localparam bit REST = 1'b1;
`else
  localparam bit REST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arrow_track_if #(.DEPTH(DEPTH), .CODE_W(CODE_W), .SCORE_W(SCORE_W)) bus();
  arrow_track #(.DEPTH(DEPTH), .CODE_W(CODE_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  int vectors = 0, errors = 0;

  // reference model: plain slot array and counters
  int         slots[DEPTH];
  bit         m_judged, m_parity, m_hit, m_miss;
  int         m_score, m_combo;
  logic [3:0] m_prev;

  typedef struct {
    bit play; bit beat; logic [3:0] arrow; logic [3:0] btn;
    bit hit; bit miss; int score; int combo; int slot0;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (slots[k]) slots[k] = 0;
    m_judged = 0; m_parity = 0; m_hit = 0; m_miss = 0;
    m_score = 0; m_combo = 0; m_prev = 4'b0;
  endtask

  task automatic model_step(input bit play, input bit beat, input logic [3:0] arrow, input logic [3:0] btn);
    logic [3:0] pr;
    pr = btn & ~m_prev;
    m_prev = btn;
    m_hit = 0; m_miss = 0;
    if (play && slots[0] != 0 && !m_judged && pr != 4'b0) begin
      if (pr == 4'(1 << (slots[0] - 10))) m_hit = 1; else m_miss = 1;
      m_judged = 1;
    end
    if (play && beat) begin
      if (slots[0] != 0 && !m_judged) m_miss = 1;
      for (int k = 0; k < DEPTH-1; k++) slots[k] = slots[k+1];
      slots[DEPTH-1] = (arrow >= 10 && arrow <= 13 && !(REST && m_parity)) ? int'(arrow) : 0;
      m_parity = !m_parity;
      m_judged = 0;
    end
    if (m_hit) begin
      if (m_score < SMAX) m_score++;
      if (m_combo < 127)  m_combo++;
    end
    if (m_miss) m_combo = 0;
  endtask

  function automatic logic [DEPTH*CODE_W-1:0] model_track();
    logic [DEPTH*CODE_W-1:0] t;
    for (int k = 0; k < DEPTH; k++) t[k*CODE_W +: CODE_W] = CODE_W'(slots[k]);
    return t;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".track"}, 64'(bus.track), 64'(model_track()));
    chk({tag, ".hit"},   64'(bus.hit),   64'(m_hit));
    chk({tag, ".miss"},  64'(bus.miss),  64'(m_miss));
    chk({tag, ".score"}, 64'(bus.score), 64'(m_score));
    chk({tag, ".combo"}, 64'(bus.combo), 64'(m_combo));
  endtask

  // apply inputs for one clock, then sample 1 time unit after the edge
  task automatic cyc(input bit play, input bit beat, input logic [3:0] arrow, input logic [3:0] btn,
                     input string tag);
    bus.play = play; bus.beat = beat; bus.arrow_in = arrow; bus.btn = btn;
    @(posedge clk);
    model_step(play, beat, arrow, btn);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.play = 0; bus.beat = 0; bus.arrow_in = 0; bus.btn = 0;
    #1;
    model_reset();
    check_model("rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tbl[22];
  logic [CODE_W-1:0] ent;

  initial begin
    // arrows only on odd beats so the table holds with or without rests
    tbl = '{
      '{1,1,11,4'b0000, 0,0,0,0,0},  '{1,1, 0,4'b0000, 0,0,0,0,0},
      '{1,1,12,4'b0000, 0,0,0,0,0},  '{1,1, 0,4'b0000, 0,0,0,0,0},
      '{1,1,13,4'b0000, 0,0,0,0,0},  '{1,1, 0,4'b0000, 0,0,0,0,0},
      '{1,1,10,4'b0000, 0,0,0,0,0},  '{1,1, 0,4'b0000, 0,0,0,0,11},
      '{1,0, 0,4'b0010, 1,0,1,1,11}, '{1,0, 0,4'b0000, 0,0,1,1,11},
      '{1,0, 0,4'b0010, 0,0,1,1,11}, '{1,1, 0,4'b0000, 0,0,1,1,0},
      '{1,0, 0,4'b0001, 0,0,1,1,0},  '{1,1, 0,4'b0000, 0,0,1,1,12},
      '{1,0, 0,4'b0001, 0,1,1,0,12}, '{1,1, 0,4'b0000, 0,0,1,0,0},
      '{1,1, 0,4'b0000, 0,0,1,0,13}, '{1,1, 0,4'b1000, 1,0,2,1,0},
      '{1,1, 0,4'b0000, 0,0,2,1,10}, '{1,1, 0,4'b0000, 0,1,2,0,0},
      '{1,0, 0,4'b0011, 0,0,2,0,0},  '{0,1,12,4'b0000, 0,0,2,0,0}
    };
    model_reset();

    // fill the track with arrow 11
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 4'd11, 4'b0, "fill");
    for (int k = 0; k < DEPTH; k++) begin
      ent = bus.track[k*CODE_W +: CODE_W];
      chk("fill.slot", 64'(ent), (REST && (k % 2 == 1)) ? 64'd0 : 64'd11);
    end

    // entry sequence with and without rests
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 4'd10, 4'b0, "entry");
      ent = bus.track[(DEPTH-1)*CODE_W +: CODE_W];
      chk("entry.slot", 64'(ent), (REST && (i % 2 == 1)) ? 64'd0 : 64'd10);
    end

    // directed table
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].play, tbl[i].beat, tbl[i].arrow, tbl[i].btn, "tbl");
      chk("tbl.hit",   64'(bus.hit),   64'(tbl[i].hit));
      chk("tbl.miss",  64'(bus.miss),  64'(tbl[i].miss));
      chk("tbl.score", 64'(bus.score), 64'(tbl[i].score));
      chk("tbl.combo", 64'(bus.combo), 64'(tbl[i].combo));
      ent = bus.track[CODE_W-1:0];
      chk("tbl.slot0", 64'(ent), 64'(tbl[i].slot0));
    end

    // invalid code enters as empty, frozen track, then reset mid-run
    cyc(1, 1, 4'd5, 4'b0, "inv");
    ent = bus.track[(DEPTH-1)*CODE_W +: CODE_W];
    chk("inv.entry", 64'(ent), 64'd0);
    cyc(1, 1, 4'd12, 4'b0, "frz.pre");
    cyc(1, 1, 4'd13, 4'b0, "frz.pre");
    for (int i = 0; i < 6; i++) cyc(0, 1, 4'd11, 4'(i % 2 ? 4'b0000 : 4'b1111), "frz");
    chk("frz.score", 64'(bus.score), 64'd2);
    do_reset();
    cyc(1, 1, 4'd0, 4'b0, "post_rst");
    chk("post_rst.track", 64'(bus.track), 64'd0);

    // saturation of score and combo
    do_reset();
    for (int i = 0; i < (REST ? 2400 : 1200); i++) begin
      cyc(1, 1, 4'd10, 4'b0000, "sat");
      cyc(1, 0, 4'd0,  4'b0001, "sat");
    end
    chk("sat.score", 64'(bus.score), 64'(SMAX));
    chk("sat.combo", 64'(bus.combo), 64'd127);

    // random run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit p, b;
      logic [3:0] a, bt;
      int r;
      if ($urandom_range(0, 499) == 0) do_reset();
      p  = ($urandom_range(0, 9) != 0);
      b  = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 1) ? 4'(10 + $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      r  = $urandom_range(0, 3);
      bt = (r < 2) ? 4'b0000 : (r == 2) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cyc(p, b, a, bt, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/arrow_track.md
ARROW_TRACK -- requirements
Module: arrow_track

Interface
REQ-001 Parameter DEPTH, default 8: number of track slots; slot 0 is the hit zone, slot DEPTH-1 is the entry slot.
REQ-002 Parameter CODE_W, default 4: width of an arrow code.
REQ-003 Parameter SCORE_W, default 10: width of the score counter.
REQ-004 clk  input  1  system clock; one clock, all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 play  input  1  high = game running; low = track frozen.
REQ-007 beat  input  1  single-cycle metronome pulse, synchronous to clk.
REQ-008 arrow_in  input  CODE_W  arrow code from the random generator; valid codes 10..13 select arrows 0..3.
REQ-009 btn  input  4  player buttons, level, already debounced; bit i = arrow i.
REQ-010 track  output  DEPTH*CODE_W  slot contents, slot k at bits [k*CODE_W +: CODE_W]; 0 = empty.
REQ-011 hit  output  1  one-cycle pulse on a correct press.
REQ-012 miss  output  1  one-cycle pulse on a wrong press or an unjudged arrow leaving slot 0.
REQ-013 score  output  SCORE_W  total hits.
REQ-014 combo  output  7  current consecutive-hit count.

Function
REQ-015 Press detection: a press is a rising edge of btn[i], using a 4-bit register of the previous btn value that updates every cycle, including while play is low.
REQ-016 Judge flag: one judged bit is kept for slot 0 and is cleared on every shift.
REQ-017 Valid press on a live arrow: when play=1, slot 0 is non-empty and judged=0, a press is judged.
- Press of exactly the matching button only -> hit, score+1, combo+1, judged set.
- Any other press pattern (wrong button, or multiple buttons) -> miss, combo=0, judged set.
REQ-018 Ignored presses: presses while slot 0 is empty, while judged=1, or while play=0 have no effect.
REQ-019 Shift on beat: on beat with play=1, slot[k] <= slot[k+1] for k < DEPTH-1, and slot[DEPTH-1] <= insert value.
REQ-020 Insert value is arrow_in if it lies in 10..13, else 0.
REQ-021 Departure miss: on a shift, if old slot 0 is non-empty and still unjudged after REQ-022 is applied, miss pulses and combo=0.
REQ-022 Press and beat in the same cycle: the press is judged against the pre-shift slot 0 first; a resulting hit suppresses the departure miss; hit and miss never pulse in the same cycle.
REQ-023 Output timing: hit and miss are registered and assert the cycle after the triggering edge, for exactly one cycle.
REQ-024 Counter updates: score and combo update in that same cycle as hit/miss.
REQ-025 Saturation: score saturates at 2^SCORE_W-1 and combo at 127; neither wraps.
REQ-026 Frozen track: with play=0, track, judged, score and combo hold; beats are ignored.
REQ-027 track is a direct register output (zero combinational logic).

Reset
REQ-028 rst=1 immediately clears:
- all slots to 0 (track=0),
- judged, the previous-btn register and the beat parity bit,
- hit, miss, score and combo to 0.
REQ-029 Reset mid-game discards all queued arrows; the first post-reset beat shifts into an all-empty track.

Configuration
REQ-030 Macro ARROW_TRACK_REST_EN.
- Defined: a 1-bit beat parity toggles on each accepted beat; beats with parity 1 before toggling insert 0 (rest) regardless of arrow_in, so arrows enter on every other beat starting with the first.
- Undefined: no parity register exists and every accepted beat inserts per REQ-020.

Verification
REQ-031 Scenario: reset, play=1, 8 beats with arrow_in=11 -> track all slots 11; no hit/miss.
REQ-032 Scenario: slot 0 = 11, press btn[1] -> hit one cycle later, score=1, combo=1; second press btn[1] before next beat -> no pulse.
REQ-033 Scenario: slot 0 = 12, press btn[0] -> miss, combo=0; next beat -> no additional miss.
REQ-034 Scenario: slot 0 = 13 unjudged, beat with no press -> miss; press btn[3] in the beat cycle instead -> hit only.
REQ-035 Scenario: arrow_in=5 on a beat -> entry slot 0. Then play=0 with beats and presses -> track, score and combo unchanged. Then assert rst mid-run -> all outputs 0 immediately.
REQ-036 Scenario: with ARROW_TRACK_REST_EN, 4 beats of arrow_in=10 -> entry sequence 10,0,10,0; without the macro -> 10,10,10,10.
